// File: rtl/ahb_tohost_monitor.sv
// -----------------------------------------------------------------------------
// ahb_tohost_monitor
//
// Snoops the data-side AHB-Lite master bus of each hart. It detects the
// riscv-tests "tohost" completion write and records a pass/fail verdict and
// the raw code per hart. It also aggregates a chip-level FINISH / FINISH_FAIL
// verdict and runs a watchdog cycle counter.
//
// Ports
//   CLK, RES_N        clock (rising edge), asynchronous active-low reset
//   CLEAR             synchronous clear of all results and the cycle counter
//   M_H*              per-hart AHB-Lite master signals, hart n in slice n
//   HART_DONE         sticky, hart n has written tohost
//   HART_FAIL         sticky, the written value was not PASS_VALUE
//   FAIL_CODE         HWDATA of the first tohost write of each hart (32b/hart)
//   FINISH            every hart done (registered, one edge after last done)
//   FINISH_FAIL       FINISH and at least one hart failed
//   TIMEOUT           sticky, watchdog expired before FINISH
//   CYCLE_COUNT       cycles since reset/CLEAR, frozen at FINISH or TIMEOUT
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module ahb_tohost_monitor #(
    parameter int          HART_COUNT  = 1,
    parameter logic [31:0] TOHOST_ADDR = 32'h0000_1000,
    parameter logic [31:0] HART_STRIDE = 32'h0100_0000,
    parameter logic [31:0] PASS_VALUE  = 32'h0000_0001,
    parameter int unsigned TIMEOUT_CYC = 400000
) (
    input  logic                     CLK,
    input  logic                     RES_N,
    input  logic                     CLEAR,
    input  logic [HART_COUNT-1:0]    M_HSEL,
    input  logic [2*HART_COUNT-1:0]  M_HTRANS,
    input  logic [HART_COUNT-1:0]    M_HWRITE,
    input  logic [3*HART_COUNT-1:0]  M_HSIZE,
    input  logic [32*HART_COUNT-1:0] M_HADDR,
    input  logic [32*HART_COUNT-1:0] M_HWDATA,
    input  logic [HART_COUNT-1:0]    M_HREADY,
    input  logic [HART_COUNT-1:0]    M_HREADYOUT,
    output logic [HART_COUNT-1:0]    HART_DONE,
    output logic [HART_COUNT-1:0]    HART_FAIL,
    output logic [32*HART_COUNT-1:0] FAIL_CODE,
    output logic                     FINISH,
    output logic                     FINISH_FAIL,
    output logic                     TIMEOUT,
    output logic [31:0]              CYCLE_COUNT
);

    localparam logic [1:0]  ST_IDLE   = 2'd0;
    localparam logic [1:0]  ST_ARMED  = 2'd1;
    localparam logic [1:0]  ST_DONE   = 2'd2;
    localparam bit          WDOG_EN   = (TIMEOUT_CYC != 32'd0);
    localparam logic [31:0] WDOG_LAST = TIMEOUT_CYC - 32'd1;
    localparam logic [31:0] COUNT_MAX = 32'hFFFF_FFFF;

    logic [1:0]               state_r      [HART_COUNT];
    logic [1:0]               state_next_s [HART_COUNT];
    logic [HART_COUNT-1:0]    done_r;
    logic [HART_COUNT-1:0]    done_next_s;
    logic [HART_COUNT-1:0]    fail_r;
    logic [HART_COUNT-1:0]    fail_next_s;
    logic [32*HART_COUNT-1:0] code_r;
    logic [32*HART_COUNT-1:0] code_next_s;
    logic [HART_COUNT-1:0]    xfer_ok_s;
    logic [HART_COUNT-1:0]    addr_hit_s;
    logic                     finish_r;
    logic                     timeout_r;
    logic [31:0]              count_r;
    logic                     timeout_hit_s;

    // Per-hart decode: a completed address phase of a word write to this hart's tohost
    for (genvar n = 0; n < HART_COUNT; n++) begin : g_hart
        localparam logic [31:0] HART_ADDR = TOHOST_ADDR + HART_STRIDE * 32'(n);
        logic unused_htrans0_s;

        // HTRANS[0] only separates NONSEQ from SEQ (and IDLE from BUSY); both halves behave alike here
        assign unused_htrans0_s = M_HTRANS[2*n];
        assign xfer_ok_s[n]     = M_HREADY[n] & M_HREADYOUT[n];
        assign addr_hit_s[n]    = xfer_ok_s[n] & M_HSEL[n] & M_HTRANS[2*n+1] & M_HWRITE[n] &
                                  (M_HSIZE[3*n +: 3] == 3'b010) &
                                  (M_HADDR[32*n +: 32] == HART_ADDR);
    end

    // Per-hart FSM next state and data-phase capture of the verdict
    always_comb begin
        done_next_s = done_r;
        fail_next_s = fail_r;
        code_next_s = code_r;
        for (int n = 0; n < HART_COUNT; n++) begin
            state_next_s[n] = state_r[n];
            case (state_r[n])
                ST_IDLE: begin
                    if (addr_hit_s[n]) begin
                        state_next_s[n] = ST_ARMED;
                    end else begin
                        state_next_s[n] = ST_IDLE;
                    end
                end
                ST_ARMED: begin
                    // A new address phase overlapping this data phase is dropped: DONE is terminal
                    if (xfer_ok_s[n]) begin
                        state_next_s[n]         = ST_DONE;
                        done_next_s[n]          = 1'b1;
                        fail_next_s[n]          = (M_HWDATA[32*n +: 32] != PASS_VALUE);
                        code_next_s[32*n +: 32] = M_HWDATA[32*n +: 32];
                    end else begin
                        state_next_s[n] = ST_ARMED;
                    end
                end
                ST_DONE: begin
                    state_next_s[n] = ST_DONE;
                end
                default: begin
                    state_next_s[n] = ST_IDLE;
                end
            endcase
        end
    end

    // Watchdog fires on the limit edge unless every hart is done by that same edge (FINISH wins)
    assign timeout_hit_s = WDOG_EN & ~finish_r & ~timeout_r &
                           (count_r == WDOG_LAST) & ~(&done_next_s);

    // All state: per-hart FSMs, verdicts, chip verdict and watchdog counter
    always_ff @(posedge CLK or negedge RES_N) begin
        if (!RES_N) begin
            for (int n = 0; n < HART_COUNT; n++) begin
                state_r[n] <= ST_IDLE;
            end
            done_r    <= '0;
            fail_r    <= '0;
            code_r    <= '0;
            finish_r  <= 1'b0;
            timeout_r <= 1'b0;
            count_r   <= 32'd0;
        end else if (CLEAR) begin
            for (int n = 0; n < HART_COUNT; n++) begin
                state_r[n] <= ST_IDLE;
            end
            done_r    <= '0;
            fail_r    <= '0;
            code_r    <= '0;
            finish_r  <= 1'b0;
            timeout_r <= 1'b0;
            count_r   <= 32'd0;
        end else begin
            for (int n = 0; n < HART_COUNT; n++) begin
                state_r[n] <= state_next_s[n];
            end
            done_r    <= done_next_s;
            fail_r    <= fail_next_s;
            code_r    <= code_next_s;
            finish_r  <= finish_r | (&done_r);
            timeout_r <= timeout_r | timeout_hit_s;
            if (!finish_r && !timeout_r && (count_r != COUNT_MAX)) begin
                count_r <= count_r + 32'd1;
            end
        end
    end

    assign HART_DONE   = done_r;
    assign HART_FAIL   = fail_r;
    assign FAIL_CODE   = code_r;
    assign FINISH      = finish_r;
    assign FINISH_FAIL = finish_r & (|fail_r);
    assign TIMEOUT     = timeout_r;
    assign CYCLE_COUNT = count_r;

endmodule

// File: tb/tb_ahb_tohost_monitor.sv
// -----------------------------------------------------------------------------
// tb_ahb_tohost_monitor
//
// Bench for ahb_tohost_monitor with two harts and a 100-cycle watchdog.
// Single tohost transactions come from a vector table, and their expected
// verdicts go through a scoreboard queue. Hand-written sequences cover
// FINISH, the watchdog, sticky verdicts, CLEAR and asynchronous reset.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_ahb_tohost_monitor;

    localparam int HC = 2;

    logic            tb_clk = 1'b0;
    logic            res_n;
    logic            clear;
    logic [HC-1:0]   hsel;
    logic [2*HC-1:0] htrans;
    logic [HC-1:0]   hwrite;
    logic [3*HC-1:0] hsize;
    logic [32*HC-1:0] haddr;
    logic [32*HC-1:0] hwdata;
    logic [HC-1:0]   hready;
    logic [HC-1:0]   hreadyout;
    logic [HC-1:0]   hart_done;
    logic [HC-1:0]   hart_fail;
    logic [32*HC-1:0] fail_code;
    logic            finish;
    logic            finish_fail;
    logic            timeout;
    logic [31:0]     cycle_count;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    typedef struct {
        int          hart;
        logic        sel;
        logic [1:0]  trans;
        logic        wr;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [31:0] data;
        int          waits;
        logic        exp_done;
        logic        exp_fail;
        logic [31:0] exp_code;
    } vec_t;

    typedef struct {
        logic [HC-1:0]    done;
        logic [HC-1:0]    fail;
        logic [32*HC-1:0] code;
    } exp_t;

    vec_t vecs [12];
    exp_t sb_q [$];

    always #5 tb_clk = ~tb_clk;

    ahb_tohost_monitor #(
        .HART_COUNT (HC),
        .TIMEOUT_CYC(100)
    ) dut (
        .CLK        (tb_clk),
        .RES_N      (res_n),
        .CLEAR      (clear),
        .M_HSEL     (hsel),
        .M_HTRANS   (htrans),
        .M_HWRITE   (hwrite),
        .M_HSIZE    (hsize),
        .M_HADDR    (haddr),
        .M_HWDATA   (hwdata),
        .M_HREADY   (hready),
        .M_HREADYOUT(hreadyout),
        .HART_DONE  (hart_done),
        .HART_FAIL  (hart_fail),
        .FAIL_CODE  (fail_code),
        .FINISH     (finish),
        .FINISH_FAIL(finish_fail),
        .TIMEOUT    (timeout),
        .CYCLE_COUNT(cycle_count)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge tb_clk);
        #1;
        cyc++;
    endtask

    task automatic idle_bus();
        hsel      = '0;
        htrans    = '0;
        hwrite    = '0;
        hsize     = '0;
        haddr     = '0;
        hwdata    = '0;
        hready    = '1;
        hreadyout = '1;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        cyc   = 0;
    endtask

    task automatic addr_phase(input int h, input logic sel, input logic [1:0] trans,
                              input logic wr, input logic [2:0] size, input logic [31:0] addr);
        hsel[h]           = sel;
        htrans[2*h +: 2]  = trans;
        hwrite[h]         = wr;
        hsize[3*h +: 3]   = size;
        haddr[32*h +: 32] = addr;
        tick();
        hsel[h]           = 1'b0;
        htrans[2*h +: 2]  = 2'b00;
        hwrite[h]         = 1'b0;
        hsize[3*h +: 3]   = 3'b000;
        haddr[32*h +: 32] = 32'h0;
    endtask

    task automatic data_phase(input int h, input logic [31:0] data, input int waits);
        hwdata[32*h +: 32] = data;
        for (int w = 0; w < waits; w++) begin
            hready[h]    = 1'b0;
            hreadyout[h] = 1'b0;
            tick();
            check("wait_hold", 64'(hart_done[h]), 64'(1'b0));
        end
        hready[h]    = 1'b1;
        hreadyout[h] = 1'b1;
        tick();
        hwdata[32*h +: 32] = 32'h0;
    endtask

    task automatic tohost_write(input int h, input logic [31:0] data, input int waits);
        addr_phase(h, 1'b1, 2'b10, 1'b1, 3'b010, 32'h0000_1000 + 32'h0100_0000 * 32'(h));
        data_phase(h, data, waits);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "bench time limit");
    end

    initial begin
        logic [31:0] frozen;
        exp_t        e;

        vecs[0]  = '{0, 1'b1, 2'b10, 1'b1, 3'b010, 32'h0000_1000, 32'h0000_0001, 0, 1'b1, 1'b0, 32'h0000_0001};
        vecs[1]  = '{0, 1'b1, 2'b10, 1'b1, 3'b010, 32'h0000_1000, 32'h0000_0005, 0, 1'b1, 1'b1, 32'h0000_0005};
        vecs[2]  = '{1, 1'b1, 2'b10, 1'b1, 3'b010, 32'h0100_1000, 32'h0000_0007, 3, 1'b1, 1'b1, 32'h0000_0007};
        vecs[3]  = '{0, 1'b1, 2'b10, 1'b1, 3'b000, 32'h0000_1000, 32'h0000_0001, 0, 1'b0, 1'b0, 32'h0};
        vecs[4]  = '{0, 1'b1, 2'b10, 1'b0, 3'b010, 32'h0000_1000, 32'h0000_0001, 0, 1'b0, 1'b0, 32'h0};
        vecs[5]  = '{0, 1'b1, 2'b10, 1'b1, 3'b010, 32'h0000_1004, 32'h0000_0001, 0, 1'b0, 1'b0, 32'h0};
        vecs[6]  = '{1, 1'b1, 2'b10, 1'b1, 3'b010, 32'h0000_1000, 32'h0000_0001, 0, 1'b0, 1'b0, 32'h0};
        vecs[7]  = '{0, 1'b1, 2'b01, 1'b1, 3'b010, 32'h0000_1000, 32'h0000_0001, 0, 1'b0, 1'b0, 32'h0};
        vecs[8]  = '{0, 1'b0, 2'b10, 1'b1, 3'b010, 32'h0000_1000, 32'h0000_0001, 0, 1'b0, 1'b0, 32'h0};
        vecs[9]  = '{0, 1'b1, 2'b11, 1'b1, 3'b010, 32'h0000_1000, 32'hDEAD_BEEF, 1, 1'b1, 1'b1, 32'hDEAD_BEEF};
        vecs[10] = '{0, 1'b1, 2'b10, 1'b1, 3'b001, 32'h0000_1000, 32'h0000_0001, 0, 1'b0, 1'b0, 32'h0};
        vecs[11] = '{1, 1'b1, 2'b10, 1'b1, 3'b010, 32'h0100_1000, 32'h0000_0001, 2, 1'b1, 1'b0, 32'h0000_0001};

        // Reset state
        res_n = 1'b0;
        clear = 1'b0;
        idle_bus();
        #12;
        check("rst_done",   64'(hart_done),   64'(2'b00));
        check("rst_fail",   64'(hart_fail),   64'(2'b00));
        check("rst_code",   64'(fail_code),   64'h0);
        check("rst_finish", 64'(finish),      64'(1'b0));
        check("rst_ffail",  64'(finish_fail), 64'(1'b0));
        check("rst_tmo",    64'(timeout),     64'(1'b0));
        check("rst_count",  64'(cycle_count), 64'h0);
        res_n = 1'b1;

        // Table-driven single transactions through the scoreboard
        for (int i = 0; i < 12; i++) begin
            do_clear();
            e.done = '0;
            e.fail = '0;
            e.code = '0;
            e.done[vecs[i].hart]            = vecs[i].exp_done;
            e.fail[vecs[i].hart]            = vecs[i].exp_fail;
            e.code[32*vecs[i].hart +: 32]   = vecs[i].exp_code;
            sb_q.push_back(e);
            addr_phase(vecs[i].hart, vecs[i].sel, vecs[i].trans, vecs[i].wr,
                       vecs[i].size, vecs[i].addr);
            data_phase(vecs[i].hart, vecs[i].data, vecs[i].waits);
            e = sb_q.pop_front();
            check($sformatf("vec%0d_done", i),   64'(hart_done), 64'(e.done));
            check($sformatf("vec%0d_fail", i),   64'(hart_fail), 64'(e.fail));
            check($sformatf("vec%0d_code", i),   64'(fail_code), 64'(e.code));
            check($sformatf("vec%0d_finish", i), 64'(finish),    64'(1'b0));
        end

        // Both harts finish, hart1 fails with 3 wait states
        do_clear();
        tohost_write(0, 32'h0000_0001, 0);
        tohost_write(1, 32'h0000_0007, 3);
        check("fin_done",      64'(hart_done), 64'(2'b11));
        check("fin_code",      64'(fail_code), {32'h0000_0007, 32'h0000_0001});
        check("fin_early",     64'(finish),    64'(1'b0));
        tick();
        check("fin_finish",    64'(finish),      64'(1'b1));
        check("fin_ffail",     64'(finish_fail), 64'(1'b1));
        check("fin_count",     64'(cycle_count), 64'(cyc));
        frozen = 32'(cyc);
        repeat (5) tick();
        check("fin_frozen",    64'(cycle_count), 64'(frozen));
        check("fin_no_tmo",    64'(timeout),     64'(1'b0));

        // CLEAR while DONE, then a fresh capture
        clear = 1'b1;
        tick();
        clear = 1'b0;
        cyc   = 0;
        check("clr_done",   64'(hart_done),   64'(2'b00));
        check("clr_fail",   64'(hart_fail),   64'(2'b00));
        check("clr_code",   64'(fail_code),   64'h0);
        check("clr_finish", 64'(finish),      64'(1'b0));
        check("clr_ffail",  64'(finish_fail), 64'(1'b0));
        check("clr_count",  64'(cycle_count), 64'h0);
        tohost_write(0, 32'h0000_0009, 0);
        check("reuse_done", 64'(hart_done), 64'(2'b01));
        check("reuse_fail", 64'(hart_fail), 64'(2'b01));
        check("reuse_code", 64'(fail_code), 64'h0000_0000_0000_0009);

        // CLEAR beats a capture on the same edge
        do_clear();
        addr_phase(0, 1'b1, 2'b10, 1'b1, 3'b010, 32'h0000_1000);
        hwdata[31:0] = 32'h0000_0001;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        cyc   = 0;
        tick();
        hwdata = '0;
        check("clrpri_done", 64'(hart_done), 64'(2'b00));
        check("clrpri_code", 64'(fail_code), 64'h0);

        // Sticky first verdict
        do_clear();
        tohost_write(0, 32'h0000_0005, 0);
        tohost_write(0, 32'h0000_0001, 0);
        check("sticky_fail", 64'(hart_fail), 64'(2'b01));
        check("sticky_code", 64'(fail_code), 64'h0000_0000_0000_0005);

        // Watchdog expiry
        do_clear();
        while (cyc < 99) tick();
        check("tmo_before", 64'(timeout),     64'(1'b0));
        check("tmo_cnt99",  64'(cycle_count), 64'd99);
        tick();
        check("tmo_set",    64'(timeout),     64'(1'b1));
        check("tmo_cnt100", 64'(cycle_count), 64'd100);
        repeat (5) tick();
        check("tmo_frozen", 64'(cycle_count), 64'd100);
        check("tmo_sticky", 64'(timeout),     64'(1'b1));
        check("tmo_nofin",  64'(finish),      64'(1'b0));

        // Last HART_DONE on the watchdog limit edge: FINISH wins
        do_clear();
        tohost_write(0, 32'h0000_0001, 0);
        while (cyc < 98) tick();
        tohost_write(1, 32'h0000_0001, 0);
        check("race_done",   64'(hart_done),   64'(2'b11));
        check("race_tmo0",   64'(timeout),     64'(1'b0));
        check("race_cnt",    64'(cycle_count), 64'd100);
        tick();
        check("race_finish", 64'(finish),      64'(1'b1));
        check("race_ffail",  64'(finish_fail), 64'(1'b0));
        check("race_tmo1",   64'(timeout),     64'(1'b0));
        check("race_cnt2",   64'(cycle_count), 64'd101);
        repeat (3) tick();
        check("race_tmo2",   64'(timeout),     64'(1'b0));

        // Asynchronous reset while hart1 is ARMED
        do_clear();
        tohost_write(0, 32'h0000_0001, 0);
        addr_phase(1, 1'b1, 2'b10, 1'b1, 3'b010, 32'h0100_1000);
        #2;
        res_n = 1'b0;
        #1;
        check("arst_done",  64'(hart_done),   64'(2'b00));
        check("arst_count", 64'(cycle_count), 64'h0);
        res_n = 1'b1;
        cyc   = 0;
        data_phase(1, 32'h0000_0001, 0);
        check("arst_nocap", 64'(hart_done),   64'(2'b00));
        check("arst_cnt",   64'(cycle_count), 64'(cyc));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
